// File: rtl/trivium_pkg.sv
// -----------------------------------------------------------------------------
// trivium_pkg
// Shared types and constants for the trivium stream controller slice.
//   state_t               : sequencer states (IDLE, LOAD, WARMUP, GATHER)
//   TRIVIUM_KEY_W/IV_W    : fixed trivium key and IV widths
//   TRIVIUM_WARMUP_CYCLES : number of core rounds before keystream is usable
//   ksCntWidth()          : width of the keystream bit counter for a word width
// -----------------------------------------------------------------------------
package trivium_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    WARMUP = 2'd2,
    GATHER = 2'd3
  } state_t;

  localparam int TRIVIUM_KEY_W         = 80;
  localparam int TRIVIUM_IV_W          = 80;
  localparam int TRIVIUM_WARMUP_CYCLES = 1152;

  // A one-bit word still needs a one-bit counter.
  function automatic int ksCntWidth(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/trivium_ks_gather.sv
// -----------------------------------------------------------------------------
// trivium_ks_gather
// Collects keystream bits from the trivium core into W-bit words, MSB first.
// Optional macro TRIVIUM_STREAM_CTRL_PREFETCH_EN adds a second word buffer so
// gathering can continue while a completed word waits to be consumed.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_en         : core is enabled this cycle, shift in i_bit
//   i_bit        : keystream bit from the core
//   i_pop        : the current keystream word is consumed this cycle
//   i_clear      : discard all gathered bits and words
//   o_ks_word    : current keystream word
//   o_ks_valid   : o_ks_word is complete
//   o_full       : no room for another word, core must stall
// -----------------------------------------------------------------------------
module trivium_ks_gather
  import trivium_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_bit,
  input  logic         i_pop,
  input  logic         i_clear,
  output logic [W-1:0] o_ks_word,
  output logic         o_ks_valid,
  output logic         o_full
);

  localparam int CNT_W = ksCntWidth(W);

  logic [W-1:0]     r_shift;
  logic [CNT_W-1:0] r_ks_cnt;
  logic [W-1:0]     r_ks_word;
  logic             r_ks_valid;

  logic [W-1:0]     w_shift_next;
  logic             w_word_done;

  // The oldest bit ends up in bit W-1 once W bits have been shifted in.
  assign w_shift_next = W'({r_shift, i_bit});
  assign w_word_done  = i_en && (r_ks_cnt == CNT_W'(W - 1));

  // Shift register and bit counter; the counter wraps as each word completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_ks_cnt <= '0;
    end else if (i_clear) begin
      r_shift  <= '0;
      r_ks_cnt <= '0;
    end else if (i_en) begin
      r_shift  <= w_shift_next;
      r_ks_cnt <= w_word_done ? '0 : r_ks_cnt + 1'b1;
    end
  end

`ifdef TRIVIUM_STREAM_CTRL_PREFETCH_EN
  logic [W-1:0] r_buf_word;
  logic         r_buf_valid;

  // Two-deep word store: a pop promotes the buffered word, and a word that
  // completes in the same cycle drops into whichever slot is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ks_word   <= '0;
      r_ks_valid  <= 1'b0;
      r_buf_word  <= '0;
      r_buf_valid <= 1'b0;
    end else if (i_clear) begin
      r_ks_valid  <= 1'b0;
      r_buf_valid <= 1'b0;
    end else if (i_pop) begin
      if (r_buf_valid) begin
        r_ks_word   <= r_buf_word;
        r_ks_valid  <= 1'b1;
        r_buf_valid <= w_word_done;
        if (w_word_done) begin
          r_buf_word <= w_shift_next;
        end
      end else begin
        r_ks_valid <= w_word_done;
        if (w_word_done) begin
          r_ks_word <= w_shift_next;
        end
      end
    end else if (w_word_done) begin
      if (!r_ks_valid) begin
        r_ks_word  <= w_shift_next;
        r_ks_valid <= 1'b1;
      end else begin
        r_buf_word  <= w_shift_next;
        r_buf_valid <= 1'b1;
      end
    end
  end

  assign o_full = r_ks_valid && r_buf_valid;
`else
  // Single word store: gathering stops while a word is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ks_word  <= '0;
      r_ks_valid <= 1'b0;
    end else if (i_clear || i_pop) begin
      r_ks_valid <= 1'b0;
    end else if (w_word_done) begin
      r_ks_word  <= w_shift_next;
      r_ks_valid <= 1'b1;
    end
  end

  assign o_full = r_ks_valid;
`endif

  assign o_ks_word  = r_ks_word;
  assign o_ks_valid = r_ks_valid;

endmodule

// File: rtl/trivium_stream_ctrl.sv
// -----------------------------------------------------------------------------
// trivium_stream_ctrl
// Sequencer around one trivium keystream core: latches key/IV, reseeds the
// core, waits for warm-up, then XORs W-bit keystream words onto a word stream.
// Optional macro TRIVIUM_STREAM_CTRL_PREFETCH_EN enables keystream prefetch
// (one extra buffered word, one word every W cycles).
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   cfg_valid/ready, cfg_key/iv  : key/IV handshake, accepted in IDLE only
//   core_rst, core_en            : reset/load strobe and clock enable to core
//   core_key, core_iv            : registered key/IV held for the core
//   core_warm_up_complete        : core has finished its warm-up rounds
//   core_key_stream              : keystream bit from the core
//   in_valid/ready/data/last     : input word stream
//   out_valid/ready/data/last    : output word stream (in_data ^ keystream)
//   busy                         : controller is not IDLE
// -----------------------------------------------------------------------------
module trivium_stream_ctrl
  import trivium_pkg::*;
#(
  parameter int W     = 8,
  parameter int KEY_W = TRIVIUM_KEY_W,
  parameter int IV_W  = TRIVIUM_IV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [KEY_W-1:0] cfg_key,
  input  logic [IV_W-1:0]  cfg_iv,
  output logic             core_rst,
  output logic             core_en,
  output logic [KEY_W-1:0] core_key,
  output logic [IV_W-1:0]  core_iv,
  input  logic             core_warm_up_complete,
  input  logic             core_key_stream,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic             busy
);

  state_t           r_state;
  logic             r_cfg_ready;
  logic             r_core_rst;
  logic             r_busy;
  logic [KEY_W-1:0] r_core_key;
  logic [IV_W-1:0]  r_core_iv;

  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic             r_out_last;

  logic [W-1:0]     w_ks_word;
  logic             w_ks_valid;
  logic             w_ks_full;
  logic             w_gather;
  logic             w_in_ready;
  logic             w_xfer;
  logic             w_clear;

  // A word moves only when a keystream word is ready and the output register
  // is empty or being drained in the same cycle.
  assign w_in_ready = (r_state == GATHER) && w_ks_valid &&
                      (!r_out_valid || out_ready);
  assign w_xfer     = in_valid && w_in_ready;

  // The core runs freely during warm-up and, while gathering, only when the
  // gatherer has room; otherwise it holds its state so no bit is lost.
  assign w_gather   = (r_state == GATHER) && !w_ks_full;

  // Leftover bits (including a prefetched word) are dropped at message end.
  assign w_clear    = (r_state != GATHER) || (w_xfer && in_last);

  trivium_ks_gather #(
    .W (W)
  ) u_gather (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_gather),
    .i_bit      (core_key_stream),
    .i_pop      (w_xfer),
    .i_clear    (w_clear),
    .o_ks_word  (w_ks_word),
    .o_ks_valid (w_ks_valid),
    .o_full     (w_ks_full)
  );

  // Sequencer with registered handshake/strobe outputs. cfg_ready, core_rst
  // and busy are updated together with the state so they always match it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cfg_ready <= 1'b0;
      r_core_rst  <= 1'b1;
      r_busy      <= 1'b0;
      r_core_key  <= '0;
      r_core_iv   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_core_rst <= 1'b0;
          if (cfg_valid && r_cfg_ready) begin
            r_core_key  <= cfg_key;
            r_core_iv   <= cfg_iv;
            r_state     <= LOAD;
            r_cfg_ready <= 1'b0;
            r_core_rst  <= 1'b1;
            r_busy      <= 1'b1;
          end else begin
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        LOAD: begin
          r_core_rst <= 1'b0;
          r_state    <= WARMUP;
        end
        WARMUP: begin
          if (core_warm_up_complete) begin
            r_state <= GATHER;
          end
        end
        GATHER: begin
          if (w_xfer && in_last) begin
            r_state     <= IDLE;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cfg_ready <= 1'b0;
          r_core_rst  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Output register: loads on a transfer, otherwise clears once accepted.
  // Data and last only change on a load, so they stay stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data ^ w_ks_word;
      r_out_last  <= in_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign core_rst  = r_core_rst;
  assign core_en   = (r_state == WARMUP) || w_gather;
  assign core_key  = r_core_key;
  assign core_iv   = r_core_iv;
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

endmodule
